// File: rtl/cipher_framer.sv
// Frames a cipher byte stream as SYNC, LEN, payload, XOR checksum. Payload is
// buffered in a small FIFO; a flush request sends whatever is buffered early.
module cipher_framer #(
  parameter int          DEPTH   = 8,
  parameter int          PKT_LEN = 4,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cipher_in,
  input  logic       cipher_valid,
  output logic       cipher_ready,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_state;
  logic [7:0]    r_len;
  logic [7:0]    r_chk;
  logic [7:0]    r_pay_cnt;
  logic          r_flush_pend;

  logic       w_push;
  logic       w_pop;
  logic       w_xfer;
  logic       w_start_full;
  logic       w_start_flush;
  logic [7:0] w_head;

  assign cipher_ready  = (r_count != CW'(DEPTH));
  assign w_push        = cipher_valid && cipher_ready;
  assign w_xfer        = out_valid && out_ready;
  assign w_pop         = w_xfer && (r_state == S_PAY);
  assign w_head        = r_mem[r_rd_ptr];
  // A full packet has priority; a pending flush only sends what is buffered.
  assign w_start_full  = (r_state == S_IDLE) && (r_count >= CW'(PKT_LEN));
  assign w_start_flush = (r_state == S_IDLE) && !w_start_full && r_flush_pend
                         && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cipher_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end else if (w_start_full || w_start_flush ||
                 ((r_state == S_IDLE) && (r_count == '0))) begin
      r_flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= 8'h00;
      r_chk     <= 8'h00;
      r_pay_cnt <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_full || w_start_flush) begin
            r_len     <= w_start_full ? 8'(PKT_LEN) : 8'(r_count);
            r_chk     <= 8'h00;
            r_pay_cnt <= 8'h00;
            r_state   <= S_HDR;
          end
        end
        S_HDR: if (w_xfer) r_state <= S_LEN;
        S_LEN: begin
          if (w_xfer) begin
            r_chk   <= r_chk ^ r_len;
            r_state <= S_PAY;
          end
        end
        S_PAY: begin
          if (w_xfer) begin
            r_chk     <= r_chk ^ w_head;
            r_pay_cnt <= r_pay_cnt + 8'd1;
            if (r_pay_cnt == r_len - 8'd1) r_state <= S_CHK;
          end
        end
        S_CHK:   if (w_xfer) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_data = 8'h00;
    case (r_state)
      S_HDR:   out_data = SYNC;
      S_LEN:   out_data = r_len;
      S_PAY:   out_data = w_head;
      S_CHK:   out_data = r_chk;
      default: out_data = 8'h00;
    endcase
  end

  assign out_valid = (r_state != S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_last  = (r_state == S_CHK);

endmodule

// File: tb/tb_cipher_framer.sv
// Scoreboard bench for cipher_framer: expected frames are queued as stimulus
// is driven and compared against the captured output transfers.
module tb_cipher_framer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cipher_in = 8'h00;
  logic       cipher_valid = 1'b0;
  logic       cipher_ready;
  logic       flush = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int passes = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int stall_err;
  bit timed_out;

  cipher_framer #(.DEPTH(8), .PKT_LEN(4), .SYNC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cipher_in(cipher_in), .cipher_valid(cipher_valid), .cipher_ready(cipher_ready),
    .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; returns whether the byte was accepted on the next edge.
  task automatic push_byte(input logic [7:0] b, output bit acc);
    cipher_in = b;
    cipher_valid = 1'b1;
    acc = cipher_ready;
    @(posedge clk); #1;
    cipher_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Scoreboard push: SYNC, LEN, payload, then XOR of LEN and payload with last.
  task automatic expect_frame(input logic [7:0] pay[$]);
    logic [7:0] c;
    c = 8'(pay.size());
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, c});
    foreach (pay[i]) begin
      exp_q.push_back({1'b0, pay[i]});
      c = c ^ pay[i];
    end
    exp_q.push_back({1'b1, c});
  endtask

  // Records nbytes transfers; toggle drives out_ready 1,0,1,0...
  task automatic capture(input int nbytes, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [8:0] held = '0;
    stall_err = 0;
    timed_out = 1'b0;
    while (got < nbytes && cyc < 300) begin
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (stalled && ({out_last, out_data} !== held)) stall_err++;
        if (out_ready) begin
          got_q.push_back({out_last, out_data});
          $display("xfer data=%h last=%b", out_data, out_last);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {out_last, out_data};
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (got < nbytes) timed_out = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", out_last); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", out_data); else passes++;
    checks++; if (cipher_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cipher_ready); else passes++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_packet(input bit toggle, input string tag);
    logic [7:0] p[$];
    logic [8:0] e, g;
    bit acc;
    p = '{8'h66, 8'h01, 8'h02, 8'h03};
    expect_frame(p);
    foreach (p[i]) push_byte(p[i], acc);
    capture(7, toggle);
    checks++; if (timed_out) $display("FAIL %s_timeout: got %0d bytes expected 7", tag, got_q.size()); else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      checks++; if (g !== e) $display("FAIL %s_byte: got %h expected %h", tag, g, e); else passes++;
    end
    checks++; if (stall_err !== 0) $display("FAIL %s_stall: got %0d unstable cycles expected 0", tag, stall_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL %s_busy_after: got %b expected 0", tag, busy); else passes++;
  endtask

  task automatic test_flush();
    logic [7:0] p[$];
    logic [8:0] e, g;
    bit acc;
    p = '{8'h11, 8'h22};
    expect_frame(p);
    foreach (p[i]) push_byte(p[i], acc);
    pulse_flush();
    capture(5, 1'b0);
    checks++; if (timed_out) $display("FAIL flush_timeout: got %0d bytes expected 5", got_q.size()); else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      checks++; if (g !== e) $display("FAIL flush_byte: got %h expected %h", g, e); else passes++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL flush_busy_after: got %b expected 0", busy); else passes++;
    checks++; if (dut.r_count !== '0) $display("FAIL flush_count: got %0d expected 0", dut.r_count); else passes++;
  endtask

  task automatic test_full_fifo();
    logic [7:0] p1[$], p2[$];
    logic [8:0] e, g;
    bit acc;
    int bad_acc = 0;
    int spurious = 0;
    p1 = '{8'h10, 8'h11, 8'h12, 8'h13};
    p2 = '{8'h14, 8'h15, 8'h16, 8'h17};
    expect_frame(p1);
    expect_frame(p2);
    out_ready = 1'b0;
    foreach (p1[i]) begin push_byte(p1[i], acc); if (!acc) bad_acc++; end
    foreach (p2[i]) begin push_byte(p2[i], acc); if (!acc) bad_acc++; end
    checks++; if (bad_acc !== 0) $display("FAIL fifo_accept: got %0d rejects expected 0", bad_acc); else passes++;
    checks++; if (cipher_ready !== 1'b0) $display("FAIL fifo_full_ready: got %b expected 0", cipher_ready); else passes++;
    push_byte(8'hFF, acc);
    checks++; if (acc !== 1'b0) $display("FAIL fifo_ninth: got accepted=%b expected 0", acc); else passes++;
    capture(14, 1'b0);
    checks++; if (timed_out) $display("FAIL fifo_timeout: got %0d bytes expected 14", got_q.size()); else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      checks++; if (g !== e) $display("FAIL fifo_byte: got %h expected %h", g, e); else passes++;
    end
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (spurious !== 0) $display("FAIL fifo_extra_out: got %0d valid cycles expected 0", spurious); else passes++;
    checks++; if (cipher_ready !== 1'b1) $display("FAIL fifo_drained_ready: got %b expected 1", cipher_ready); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] p[$];
    logic [8:0] e, g;
    bit acc;
    int spurious = 0;
    p = '{8'h21, 8'h32, 8'h43, 8'h54};
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h04});
    exp_q.push_back({1'b0, 8'h21});
    foreach (p[i]) push_byte(p[i], acc);
    capture(3, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      checks++; if (g !== e) $display("FAIL midrst_prefix: got %h expected %h", g, e); else passes++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (cipher_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", cipher_ready); else passes++;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (spurious !== 0) $display("FAIL midrst_after: got %0d valid cycles expected 0", spurious); else passes++;
  endtask

  task automatic test_flush_empty();
    logic [7:0] p[$];
    logic [8:0] e, g;
    bit acc;
    int spurious = 0;
    pulse_flush();
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (spurious !== 0) $display("FAIL flush_empty_out: got %0d valid cycles expected 0", spurious); else passes++;
    p = '{8'h5A, 8'hC3, 8'h0F, 8'h99};
    expect_frame(p);
    foreach (p[i]) push_byte(p[i], acc);
    capture(7, 1'b0);
    checks++; if (timed_out) $display("FAIL flush_empty_timeout: got %0d bytes expected 7", got_q.size()); else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      checks++; if (g !== e) $display("FAIL flush_empty_byte: got %h expected %h", g, e); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_full_packet(1'b0, "full_pkt");
    test_flush();
    test_full_packet(1'b1, "backpressure");
    test_full_fifo();
    test_reset_mid_frame();
    test_flush_empty();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cipher_framer.md
CIPHER_FRAMER -- requirements
Module: cipher_framer

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk (rising edge) and rst_n (asynchronous, active-low).
REQ-002 Parameter DEPTH, default 8, SHALL set the payload FIFO depth in bytes; legal values are powers of 2 from 4 to 64.
REQ-003 Parameter PKT_LEN, default 4, SHALL set the full-packet payload length in bytes; legal range is 1 to DEPTH.
REQ-004 Parameter SYNC, default 8'hA5, SHALL set the frame header byte.
REQ-005 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- cipher_in  in  8  cipher byte from the XOR encryption stage.
- cipher_valid  in  1  cipher_in is valid.
- cipher_ready  out  1  FIFO can accept a byte.
- flush  in  1  single-cycle request to send a short packet of the buffered bytes.
- out_data  out  8  framed byte stream.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data.
- out_last  out  1  marks the checksum byte, which is the final byte of a frame.
- busy  out  1  FSM not in IDLE.

Function
REQ-006 A byte SHALL be pushed into the FIFO on each clk edge where cipher_valid=1 and cipher_ready=1.
REQ-007 cipher_ready SHALL equal (count != DEPTH); it is combinational from registered count.
REQ-008 count SHALL track FIFO occupancy, 0 to DEPTH.
- A simultaneous push and pop leaves count unchanged.
- Read and write pointers wrap modulo DEPTH.
REQ-009 The FSM SHALL have the states IDLE, HDR, LEN, PAY and CHK.
REQ-010 In IDLE, a packet SHALL start when count >= PKT_LEN, with len = PKT_LEN.
- Otherwise a packet starts when flush_pend=1 and count > 0, with len = count.
- On start, len is latched, the checksum register is cleared, and the next state is HDR.
REQ-011 flush_pend SHALL be set by a flush pulse in any state.
- It is cleared on any packet start taken from IDLE.
- A flush with count = 0 in IDLE clears flush_pend and sends no frame.
REQ-012 out_valid SHALL be 1 in HDR, LEN, PAY and CHK, and 0 in IDLE.
REQ-013 out_data SHALL be, by state:
- HDR: SYNC.
- LEN: len.
- PAY: the FIFO head byte.
- CHK: the checksum.
REQ-014 The checksum SHALL be the 8-bit XOR of the LEN byte and every PAY byte; SYNC is excluded.
REQ-015 A state SHALL advance only on a transfer (out_valid=1 and out_ready=1).
- HDR advances to LEN.
- LEN advances to PAY.
- PAY pops one FIFO byte per transfer and goes to CHK after the len-th byte.
- CHK goes to IDLE.
REQ-016 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-017 out_last SHALL be 1 only in CHK.
REQ-018 In IDLE, the FSM SHALL remain in IDLE for at least one cycle after CHK completes before HDR is asserted again.
- Minimum frame period is (len+3) transfers plus 1 cycle.
REQ-019 FIFO pushes SHALL continue while a frame is being sent.
- Bytes pushed during a frame are not part of that frame's len.
REQ-020 The first HDR byte SHALL be presented on the cycle after the start condition is registered in IDLE.
REQ-021 busy SHALL be 1 when state != IDLE.

Reset
REQ-022 Asserting rst_n=0 SHALL asynchronously force:
- state to IDLE;
- count, pointers, len, checksum and flush_pend to 0;
- out_valid, out_last and busy to 0;
- out_data to 8'h00;
- cipher_ready to 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame and all buffered bytes; no bytes are emitted after release until new input arrives.
REQ-024 FIFO storage contents SHALL NOT be required to be reset.

Verification
REQ-025 Full packet: push 66,01,02,03 with out_ready=1 -> out_data A5,04,66,01,02,03,62 with out_last only on 62.
REQ-026 Flush: push 11,22, then pulse flush -> out_data A5,02,11,22,31; busy=0 afterwards; count=0.
REQ-027 Backpressure: repeat the REQ-025 stimulus with out_ready toggling 1,0 each cycle -> identical byte sequence, with data held stable on every stall cycle.
REQ-028 Full FIFO: push 8 bytes with out_ready=0 -> cipher_ready=0 after the 8th push and a 9th byte is not accepted; after out_ready=1, two frames of 4 bytes each emit the original order.
REQ-029 Reset mid-frame: assert rst_n=0 during the PAY state -> out_valid=0 and cipher_ready=1 immediately; no output occurs after release.
REQ-030 Flush with an empty FIFO: pulse flush -> no frame is emitted; a subsequent push of 4 bytes produces a normal len=04 frame.
